// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU byte-wide multiplexed memory bus.
package mem_bus_pkg;

   localparam logic [1:0] PH_ADDR_LO = 2'd0;
   localparam logic [1:0] PH_ADDR_HI = 2'd1;
   localparam logic [1:0] PH_DATA    = 2'd2;

   localparam logic [15:0] DEFAULT_PORT_ADDR = 16'hCAFE;

   typedef enum logic {
      TGT_IDLE,
      TGT_ACK
   } tgt_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous control line.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mem_bus_target.sv
// Memory-side target: collects addr-lo / addr-hi / data phases and answers
// each strobe with a 4-phase ack; backs reads/writes with a byte RAM and one output port.
module mem_bus_target
   import mem_bus_pkg::*;
#(
   parameter int          RAM_AW    = 8,
   parameter logic [15:0] PORT_ADDR = DEFAULT_PORT_ADDR,
   parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bus_strb_i,
   input  logic       bus_rd_i,
   input  logic       bus_wr_i,
   input  logic [7:0] bus_data_i,
   output logic [7:0] bus_data_o,
   output logic       bus_data_oe,
   output logic       bus_ack_o,
   output logic [7:0] port_out,
   output logic       port_stb,
   output logic       proto_err
);

   logic strb_s, rd_s, wr_s;

   sync2 u_sync_strb (.clk(clk), .rst(rst), .d_i(bus_strb_i), .q_o(strb_s));
   sync2 u_sync_rd   (.clk(clk), .rst(rst), .d_i(bus_rd_i),   .q_o(rd_s));
   sync2 u_sync_wr   (.clk(clk), .rst(rst), .d_i(bus_wr_i),   .q_o(wr_s));

   tgt_state_e  state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic        done_q, done_d;
   logic [15:0] addr_q, addr_d;
   logic        ack_q, ack_d;
   logic        oe_q, oe_d;
   logic [7:0]  dout_q, dout_d;
   logic [7:0]  port_q, port_d;
   logic        stb_q, stb_d;
   logic        err_q, err_d;

   logic [7:0]  mem_q [2**RAM_AW];
   logic        mem_we;
   logic        addr_mapped;
   logic [7:0]  ram_rdata;

   assign addr_mapped = (addr_q >> RAM_AW) == 16'd0;
   assign ram_rdata   = mem_q[addr_q[RAM_AW-1:0]];

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      done_d  = done_q;
      addr_d  = addr_q;
      ack_d   = ack_q;
      oe_d    = oe_q;
      dout_d  = dout_q;
      port_d  = port_q;
      stb_d   = 1'b0;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         TGT_IDLE: begin
            if (strb_s) begin
               state_d = TGT_ACK;
               ack_d   = 1'b1;
               // done_q marks a strobe beyond the data phase: ack it, change nothing
               if (done_q) begin
                  err_d = 1'b1;
               end else begin
                  case (phase_q)
                     PH_ADDR_LO: addr_d[7:0]  = bus_data_i;
                     PH_ADDR_HI: addr_d[15:8] = bus_data_i;
                     default: begin
                        if (rd_s && wr_s) begin
                           err_d = 1'b1;
                        end else if (wr_s) begin
                           if (addr_q == PORT_ADDR) begin
                              port_d = bus_data_i;
                              stb_d  = 1'b1;
                           end else if (addr_mapped) begin
                              mem_we = 1'b1;
                           end
                        end else if (rd_s) begin
                           dout_d = (addr_mapped && addr_q != PORT_ADDR) ? ram_rdata : OPEN_BUS;
                           oe_d   = 1'b1;
                        end
                     end
                  endcase
               end
            end else if (!rd_s && !wr_s) begin
               phase_d = PH_ADDR_LO;
               done_d  = 1'b0;
            end
         end
         TGT_ACK: begin
            if (!strb_s) begin
               state_d = TGT_IDLE;
               ack_d   = 1'b0;
               oe_d    = 1'b0;
               if (phase_q == PH_DATA) done_d  = 1'b1;
               else                    phase_d = phase_q + 2'd1;
            end
         end
         default: state_d = TGT_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TGT_IDLE;
         phase_q <= PH_ADDR_LO;
         done_q  <= 1'b0;
         addr_q  <= 16'h0000;
         ack_q   <= 1'b0;
         oe_q    <= 1'b0;
         dout_q  <= 8'h00;
         port_q  <= 8'h00;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         ack_q   <= ack_d;
         oe_q    <= oe_d;
         dout_q  <= dout_d;
         port_q  <= port_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[addr_q[RAM_AW-1:0]] <= bus_data_i;
   end

   assign bus_data_o  = dout_q;
   assign bus_data_oe = oe_q;
   assign bus_ack_o   = ack_q;
   assign port_out    = port_q;
   assign port_stb    = stb_q;
   assign proto_err   = err_q;

endmodule

// File: tb/tb_mem_bus_target.sv
// Bench for mem_bus_target: directed vector table, corner sequences and random traffic vs a byte-array model.
module tb_mem_bus_target;

   logic       clk = 1'b0;
   logic       rst;
   logic       bus_strb_i, bus_rd_i, bus_wr_i;
   logic [7:0] bus_data_i;
   logic [7:0] bus_data_o;
   logic       bus_data_oe, bus_ack_o;
   logic [7:0] port_out;
   logic       port_stb, proto_err;

   always #5 clk = ~clk;

   mem_bus_target dut (
      .clk(clk), .rst(rst),
      .bus_strb_i(bus_strb_i), .bus_rd_i(bus_rd_i), .bus_wr_i(bus_wr_i),
      .bus_data_i(bus_data_i), .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe),
      .bus_ack_o(bus_ack_o), .port_out(port_out), .port_stb(port_stb), .proto_err(proto_err)
   );

   int n_vec = 0;
   int n_err = 0;
   int stb_cnt = 0;

   always @(negedge clk) if (port_stb === 1'b1) stb_cnt++;

   // reference model: 256-byte RAM with written-mask, plus the output port
   logic [7:0] mref [256];
   bit         wrn  [256];
   logic [7:0] port_ref = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_ram(input logic [15:0] a);
      return a < 16'd256;
   endfunction

   task automatic model_wr(input logic [15:0] a, input logic [7:0] d);
      if (a == 16'hCAFE) port_ref = d;
      else if (is_ram(a)) begin
         mref[a[7:0]] = d;
         wrn[a[7:0]]  = 1'b1;
      end
   endtask

   task automatic phase(input logic [7:0] d, output logic [7:0] rdat, output logic roe);
      int n;
      bus_data_i = d;
      repeat (2) @(posedge clk);
      #1 bus_strb_i = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (bus_ack_o !== 1'b1 && n < 20);
      chk("ack_rise_latency", n, 3);
      rdat = bus_data_o;
      roe  = bus_data_oe;
      @(posedge clk); #1;
      if (roe) chk("rd_data_stable", bus_data_o, rdat);
      bus_strb_i = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (bus_ack_o !== 1'b0 && n < 20);
      chk("ack_fall_latency", n, 3);
      chk("oe_after_ack_fall", bus_data_oe, 0);
   endtask

   task automatic txn_open(input logic rd, input logic wr);
      bus_rd_i = rd;
      bus_wr_i = wr;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic txn_close();
      bus_rd_i = 1'b0;
      bus_wr_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] rdat, output logic roe);
      logic [7:0] r;
      logic       o;
      txn_open(rd, wr);
      phase(a[7:0], r, o);
      phase(a[15:8], r, o);
      phase(d, rdat, roe);
      txn_close();
   endtask

   task automatic do_reset();
      bus_strb_i = 1'b0;
      bus_rd_i   = 1'b0;
      bus_wr_i   = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      port_ref = 8'h00;
      repeat (2) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  exp_rd;
      logic [7:0]  exp_port;
      int          exp_stb;
   } vec_t;

   vec_t vt [12];

   initial begin
      logic [7:0]  rdat;
      logic        roe;
      int          s0;
      int          n;
      logic [15:0] a;
      logic [7:0]  d;
      logic        rd, wr;

      bus_data_i = 8'h00;
      do_reset();
      chk("reset_ack", bus_ack_o, 0);
      chk("reset_oe", bus_data_oe, 0);
      chk("reset_data_o", bus_data_o, 8'h00);
      chk("reset_port_out", port_out, 8'h00);
      chk("reset_port_stb", port_stb, 0);
      chk("reset_proto_err", proto_err, 0);

      //          rd    wr    addr      data   exp_rd exp_port stb
      vt[0]  = '{1'b0, 1'b1, 16'h0010, 8'h5A, 8'h00, 8'h00, 0};
      vt[1]  = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'h5A, 8'h00, 0};
      vt[2]  = '{1'b0, 1'b1, 16'h0034, 8'h11, 8'h00, 8'h00, 0};
      vt[3]  = '{1'b0, 1'b1, 16'hCAFE, 8'h42, 8'h00, 8'h42, 1};
      vt[4]  = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'h5A, 8'h42, 0};
      vt[5]  = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'hFF, 8'h42, 0};
      vt[6]  = '{1'b0, 1'b1, 16'h1234, 8'h77, 8'h00, 8'h42, 0};
      vt[7]  = '{1'b1, 1'b0, 16'h0034, 8'h00, 8'h11, 8'h42, 0};
      vt[8]  = '{1'b1, 1'b0, 16'hCAFE, 8'h00, 8'hFF, 8'h42, 0};
      vt[9]  = '{1'b0, 1'b1, 16'h00FF, 8'hA5, 8'h00, 8'h42, 0};
      vt[10] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 8'hA5, 8'h42, 0};
      vt[11] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'hFF, 8'h42, 0};

      for (int i = 0; i < 12; i++) begin
         s0 = stb_cnt;
         xfer(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].data, rdat, roe);
         if (vt[i].wr) model_wr(vt[i].addr, vt[i].data);
         if (vt[i].rd) begin
            chk("vec_rd_data", rdat, vt[i].exp_rd);
            chk("vec_rd_oe", roe, 1);
         end else begin
            chk("vec_wr_oe", roe, 0);
         end
         chk("vec_port_out", port_out, vt[i].exp_port);
         chk("vec_port_stb_cycles", stb_cnt - s0, vt[i].exp_stb);
      end
      chk("no_err_after_vectors", proto_err, 0);

      // rd and wr both asserted in the data phase
      s0 = stb_cnt;
      xfer(1'b1, 1'b1, 16'h0010, 8'h99, rdat, roe);
      chk("rdwr_proto_err", proto_err, 1);
      chk("rdwr_no_port", stb_cnt - s0, 0);
      xfer(1'b1, 1'b0, 16'h0010, 8'h00, rdat, roe);
      chk("rdwr_ram_untouched", rdat, 8'h5A);
      chk("proto_err_sticky", proto_err, 1);
      do_reset();
      chk("proto_err_cleared", proto_err, 0);

      // fourth strobe in one write transaction
      txn_open(1'b0, 1'b1);
      phase(8'h20, rdat, roe);
      phase(8'h00, rdat, roe);
      phase(8'h33, rdat, roe);
      chk("three_phases_no_err", proto_err, 0);
      phase(8'h44, rdat, roe);
      txn_close();
      model_wr(16'h0020, 8'h33);
      chk("fourth_strobe_err", proto_err, 1);
      xfer(1'b1, 1'b0, 16'h0020, 8'h00, rdat, roe);
      chk("fourth_strobe_no_effect", rdat, 8'h33);
      do_reset();

      // reset while ack is high in the address-high phase
      txn_open(1'b1, 1'b0);
      phase(8'h10, rdat, roe);
      bus_data_i = 8'h00;
      repeat (2) @(posedge clk);
      #1 bus_strb_i = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (bus_ack_o !== 1'b1 && n < 20);
      chk("midrst_ack_seen", bus_ack_o, 1);
      rst = 1'b1;
      bus_strb_i = 1'b0;
      bus_rd_i = 1'b0;
      @(posedge clk); #1;
      chk("midrst_ack_drop", bus_ack_o, 0);
      chk("midrst_oe_drop", bus_data_oe, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      xfer(1'b1, 1'b0, 16'h0010, 8'h00, rdat, roe);
      chk("midrst_read_back", rdat, 8'h5A);
      chk("midrst_read_oe", roe, 1);

      // random traffic against the model
      for (int i = 0; i < 120; i++) begin
         n = $urandom_range(0, 9);
         if (n <= 5)      a = 16'($urandom_range(0, 255));
         else if (n <= 7) a = 16'hCAFE;
         else begin
            a = 16'($urandom_range(16'h0100, 16'hFFFF));
            if (a == 16'hCAFE) a = 16'hCAFD;
         end
         d  = 8'($urandom);
         wr = 1'($urandom_range(0, 1));
         rd = ~wr;
         s0 = stb_cnt;
         xfer(rd, wr, a, d, rdat, roe);
         if (wr) begin
            model_wr(a, d);
            chk("rand_port_out", port_out, port_ref);
            chk("rand_port_stb", stb_cnt - s0, (a == 16'hCAFE) ? 1 : 0);
         end else begin
            chk("rand_rd_oe", roe, 1);
            if (!is_ram(a)) chk("rand_rd_open_bus", rdat, 8'hFF);
            else if (wrn[a[7:0]]) chk("rand_rd_ram", rdat, mref[a[7:0]]);
         end
      end
      chk("rand_no_err", proto_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
